// File: rtl/alt_pattern_checker.sv
// rtl/alt_pattern_checker.sv - receive-side lock/error checker for the alternating 0 / MY_PARAM pattern
//
// Purpose:
//   Locks onto the alternating 0 / MY_PARAM sequence and tracks the next expected symbol.
//   Once locked, it reports each mismatch and keeps a saturating error count.
//   Lock is dropped after LOSS_THRESH consecutive mismatches.
//
// Parameters:
//   MY_PARAM    non-zero pattern symbol (>= 1)
//   LOCK_CNT    consecutive correct samples needed to lock (>= 2)
//   LOSS_THRESH consecutive locked mismatches that drop lock (>= 1)
//   ERR_CNT_W   width of err_count
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   sig_input   received pattern sample
//   sample_en   sig_input valid; when low, all state is frozen and err_pulse is 0
//   clear_count synchronous clear of err_count and of the consecutive-mismatch run
//   locked      pattern lock indication
//   err_pulse   one-cycle pulse per mismatch counted while locked
//   err_count   saturating count of locked-state mismatches
//   err_sticky  (only with ALT_CHK_STICKY_EN) set on any error, held until clear_count/reset
//
// Configuration macro: ALT_CHK_STICKY_EN adds the err_sticky output.

module alt_pattern_checker #(
  parameter int MY_PARAM    = 1,
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_THRESH = 3,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(MY_PARAM):0] sig_input,
  input  logic                      sample_en,
  input  logic                      clear_count,
  output logic                      locked,
  output logic                      err_pulse,
  output logic [ERR_CNT_W-1:0]      err_count
`ifdef ALT_CHK_STICKY_EN
  ,
  output logic                      err_sticky
`endif
);

  localparam int SW = $clog2(MY_PARAM) + 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_THRESH + 1);

  localparam logic [SW-1:0] SYM_LO = '0;
  localparam logic [SW-1:0] SYM_HI = SW'(MY_PARAM);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  exp_q, exp_d;
  logic [GW-1:0]  good_q, good_d;
  logic [BW-1:0]  bad_q, bad_d;
  logic           locked_d;
  logic           pulse_d;
  logic [ERR_CNT_W-1:0] cnt_d;

  logic [SW-1:0]  exp_flip;
  logic [GW-1:0]  good_inc;
  logic [BW-1:0]  bad_inc;
  logic           match;

  assign exp_flip = (exp_q == SYM_LO) ? SYM_HI : SYM_LO;
  assign good_inc = good_q + GW'(1);
  assign bad_inc  = bad_q + BW'(1);
  assign match    = (sig_input == exp_q);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    good_d   = good_q;
    bad_d    = bad_q;
    locked_d = locked;
    pulse_d  = 1'b0;
    cnt_d    = err_count;

    if (sample_en) begin
      case (state_q)
        SEARCH: begin
          if ((sig_input == SYM_LO) || (sig_input == SYM_HI)) begin
            exp_d   = (sig_input == SYM_LO) ? SYM_HI : SYM_LO;
            good_d  = GW'(1);
            state_d = ACQUIRE;
          end
        end

        ACQUIRE: begin
          if (match) begin
            good_d = good_inc;
            exp_d  = exp_flip;
            if (good_inc == GW'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            state_d = SEARCH;
            good_d  = '0;
          end
        end

        LOCKED: begin
          // The transmitter keeps toggling regardless of what we received.
          exp_d = exp_flip;
          if (match) begin
            bad_d = '0;
          end else begin
            pulse_d = 1'b1;
            if (err_count != {ERR_CNT_W{1'b1}}) begin
              cnt_d = err_count + ERR_CNT_W'(1);
            end
            if (bad_inc == BW'(LOSS_THRESH)) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              bad_d    = '0;
              good_d   = '0;
            end else begin
              bad_d = bad_inc;
            end
          end
        end

        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          good_d   = '0;
          bad_d    = '0;
        end
      endcase
    end

    // Clear wins over the increment but never touches state or lock.
    if (clear_count) begin
      cnt_d = '0;
      bad_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      exp_q     <= SYM_LO;
      good_q    <= '0;
      bad_q     <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      locked    <= locked_d;
      err_pulse <= pulse_d;
      err_count <= cnt_d;
    end
  end

`ifdef ALT_CHK_STICKY_EN
  // An error in the same cycle as clear_count leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
    end else if (pulse_d) begin
      err_sticky <= 1'b1;
    end else if (clear_count) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule
